shift_arbiter: RTL
==================

# shift_arbiter

Two-requester arbiter and one-entry result buffer that shares a single combinational `shift` instance (32-bit barrel shifter: logical left, logical right, arithmetic right) between two clients. Each client presents a shift operation over a valid/ready handshake. The arbiter grants one operation per cycle, applies it to the shared shifter, and registers the result with the winner's ID onto a single valid/ready result port. It sits between the two execution clients and the shifter datapath.

## Interface
- No parameters. Data width is fixed at 32 and shift amount at 5 bits, matching `shift`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid`, `req1_valid` in 1: requester i presents an operation.
- `req0_ready`, `req1_ready` out 1: requester i's operation is accepted this cycle.
- `req0_data`, `req1_data` in 32: operand.
- `req0_shift`, `req1_shift` in 5: shift amount, 0–31.
- `req0_right`, `req1_right` in 1: 1 = right shift, 0 = left shift.
- `req0_arith`, `req1_arith` in 1: 1 = arithmetic. Only meaningful when right=1.
- `res_valid` out 1: result register holds a result.
- `res_ready` in 1: consumer takes the result.
- `res_data` out 32: shifted result.
- `res_id` out 1: requester index that produced `res_data`.

## Operation
- Shifter semantics:
  - right=0: `data << shift`, zero fill. The arith input is ignored.
  - right=1, arith=0: logical right shift, zero fill.
  - right=1, arith=1: arithmetic right shift, filled with data[31].
  - shift=0: passthrough.
- Buffer FSM states:
  - EMPTY: res_valid=0.
  - FULL: res_valid=1.
- `can_accept` = EMPTY, or (FULL and `res_ready`).
- Grant is combinational from the valids and `last_grant`:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester ≠ `last_grant` (round-robin).
- `reqi_ready` = `can_accept` & grant_i. At most one ready is high per cycle.
- Accept = valid & ready for the granted requester. On accept:
  - Load the shifter output into `res_data` and the index into `res_id`.
  - Set `last_grant` to the accepted index.
  - FSM moves to FULL.
- FULL & `res_ready` & no accept: move to EMPTY.
- FULL & `res_ready` & accept: stay FULL with the new result (back-to-back).
- FULL & !`res_ready`: hold `res_data`/`res_id`. Both readies are 0.
- Requester rules: payload stays stable while valid & !ready. Valid must not be withdrawn before ready. Violations are undefined.
- Consumer rule: `res_data`/`res_id` are stable while res_valid & !res_ready.
- `last_grant` changes only on accept. Idle cycles do not rotate priority.

## Timing
- Reset values: `res_valid`=0, `res_data`=0, `res_id`=0, `last_grant`=1 (requester 0 wins the first contention), FSM=EMPTY.
- `req*_ready` is 0 during reset.
- Latency: an operation accepted at edge N appears on `res_*` after edge N, i.e. one cycle.
- Throughput: one operation per cycle while `res_ready` is held high.
- Contention: with both valids held and `res_ready`=1, grants alternate 0,1,0,1… from reset.
- Reset mid-operation: `res_valid` drops asynchronously and any buffered result is discarded. Requests in flight are not accepted.
- The ready paths are combinational: valid → ready and res_ready → req_ready. There is no combinational path from req payload to res_*.

## Configuration
- `SHIFT_ARB_FIXED_PRIO_EN`:
  - Defined: requester 0 always wins contention. `last_grant` is not implemented and requester 1 may starve.
  - Undefined (default): round-robin as described above.

## Test plan
- **Single shift:** req0 data=0xAAAAAAAA, shift=1, right=0 → next cycle res_valid=1, res_data=0x55555554, res_id=0.
- **Right shifts:** req1 data=0xAAAAAAAA, shift=4, right=1 → res_data=0x0AAAAAAA with arith=0, 0xFAAAAAAA with arith=1, res_id=1. Sweep all 32 shift amounts × 3 modes against a reference model.
- **Contention:** both requesters valid for 6 cycles with res_ready=1 → res_id sequence 0,1,0,1,0,1. With `SHIFT_ARB_FIXED_PRIO_EN`: 0,0,0,0,0,0.
- **Backpressure:** res_ready=0 for 3 cycles with a result held → res_data/res_id stable, both req_ready=0. Raising res_ready → the next operation is accepted in the same cycle and appears one cycle later.
- **Reset mid-operation:** assert rst with res_valid=1 → res_valid=0 immediately and res_data=0. After release, the first contention is won by requester 0.
- **shift=0:** passthrough in all modes: 0xAAAAAAAA → 0xAAAAAAAA.

Source files
------------

// File: rtl/shift_arbiter_if.sv
// Request/result bundle for shift_arbiter: two shift requesters and one result port.
// slave  : the arbiter side (consumes requests, produces results).
// master : the client/consumer side (drives requests and res_ready).
interface shift_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_data;
  logic [4:0]  req0_shift;
  logic        req0_right;
  logic        req0_arith;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_data;
  logic [4:0]  req1_shift;
  logic        req1_right;
  logic        req1_arith;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_id;

  modport slave (
    input  req0_valid, req0_data, req0_shift, req0_right, req0_arith,
    input  req1_valid, req1_data, req1_shift, req1_right, req1_arith,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id
  );

  modport master (
    output req0_valid, req0_data, req0_shift, req0_right, req0_arith,
    output req1_valid, req1_data, req1_shift, req1_right, req1_arith,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id
  );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester arbiter sharing one 32-bit barrel shifter,
// with a one-entry registered result buffer.
// Optional macro SHIFT_ARB_FIXED_PRIO_EN: requester 0 always wins contention
// (no last_grant state). Default build is round-robin.
module shift_arbiter (
  input  logic           clk,
  input  logic           rst,
  shift_arbiter_if.slave arb
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_id_q, res_id_d;

  logic              can_accept;
  logic              grant0, grant1;
  logic              accept;
  logic              sel;

  logic [DATA_W-1:0]  sh_in, sh_out;
  logic [SHAMT_W-1:0] sh_amt;
  logic               sh_right, sh_arith;

`ifndef SHIFT_ARB_FIXED_PRIO_EN
  logic last_grant_q, last_grant_d;
`endif

  // Grant selection from the valids (and round-robin pointer when enabled)
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    grant0 = arb.req0_valid;
    grant1 = arb.req1_valid & ~arb.req0_valid;
`else
    if (arb.req0_valid && arb.req1_valid) begin
      grant0 = last_grant_q;
      grant1 = ~last_grant_q;
    end else begin
      grant0 = arb.req0_valid;
      grant1 = arb.req1_valid;
    end
`endif
  end

  // Buffer can take a new result when empty or draining this cycle; never during reset
  assign can_accept     = ~rst & ((state_q == ST_EMPTY) | arb.res_ready);
  assign arb.req0_ready = can_accept & grant0;
  assign arb.req1_ready = can_accept & grant1;
  assign accept         = arb.req0_ready | arb.req1_ready;
  assign sel            = grant1;

  // Shared barrel shifter fed by the granted requester's payload
  always_comb begin
    sh_in    = sel ? arb.req1_data  : arb.req0_data;
    sh_amt   = sel ? arb.req1_shift : arb.req0_shift;
    sh_right = sel ? arb.req1_right : arb.req0_right;
    sh_arith = sel ? arb.req1_arith : arb.req0_arith;
    sh_out   = sh_in;
    if (!sh_right) begin
      sh_out = sh_in << sh_amt;
    end else if (sh_arith) begin
      sh_out = DATA_W'($unsigned($signed(sh_in) >>> sh_amt));
    end else begin
      sh_out = sh_in >> sh_amt;
    end
  end

  // Next-state logic for the result buffer and priority pointer
  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (accept) begin
          state_d = ST_FULL;
        end else if (arb.res_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (accept) begin
      res_data_d = sh_out;
      res_id_d   = sel;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
      last_grant_d = sel;
`endif
    end
  end

  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      res_data_q <= '0;
      res_id_q   <= 1'b0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign arb.res_valid = (state_q == ST_FULL);
  assign arb.res_data  = res_data_q;
  assign arb.res_id    = res_id_q;

endmodule
